// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit
//   Hazard and forwarding controller for the 5-stage pipeline. Keeps shadow copies of the
//   destination info held in the EX, MEM and WB stages plus a one-entry retire buffer. From these
//   it raises load-use stalls, branch flushes and EX operand forwarding selects.
//
// Parameters
//   XLEN     operand / forward data width
//   REG_AW   register index width
//   BR_STAGE stage resolving branches: 2 = EX, 3 = MEM
//   CNT_W    perf counter width
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   id_*                             instruction currently in ID (indices, uses, rd, flags)
//   branch_taken                     taken branch resolved in stage BR_STAGE this cycle
//   ex_rs1_data/ex_rs2_data          register-file operands held in ID_EX
//   mem_alu_res, wb_wdata            EX_MEM ALU result, MEM_WB write-back data
//   pc_stall, ifid_stall             hold PC / IF_ID
//   ifid_flush, idex_flush,
//   exmem_flush                      load bubbles into the pipeline registers
//   fwd_a/fwd_b                      00 regfile, 10 MEM, 01 WB, 11 retire buffer
//   ex_op_a/ex_op_b                  forwarded EX operands
//   stall_cnt, flush_cnt             perf counters
//
// Optional feature: define HAZARD_PERF_EN to build the saturating stall/flush counters;
// otherwise stall_cnt and flush_cnt are tied to zero.

module pipeline_hazard_unit #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   ex_rs1_data,
    input  logic [XLEN-1:0]   ex_rs2_data,
    input  logic [XLEN-1:0]   mem_alu_res,
    input  logic [XLEN-1:0]   wb_wdata,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam bit BrInMem = (BR_STAGE == 3);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } dest_t;

    dest_t             ex_q, ex_d, mem_q, mem_d, wb_q, ret_q;
    logic              ex_memread_q, ex_memread_d, mem_memread_q, mem_memread_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic [XLEN-1:0]   ret_data_q;

    logic stall_raw, flush, stall;

    function automatic logic fwd_hit(input dest_t s, input logic [REG_AW-1:0] idx);
        return s.valid && s.regwrite && (s.rd != '0) && (s.rd == idx);
    endfunction

    // Youngest producer wins; a load in MEM has no data yet, so fall through to older stages.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] idx);
        if (fwd_hit(mem_q, idx) && !mem_memread_q) return 2'b10;
        if (fwd_hit(wb_q, idx))                    return 2'b01;
        if (fwd_hit(ret_q, idx))                   return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] op_sel(input logic [1:0] sel, input logic [XLEN-1:0] rf);
        case (sel)
            2'b10:   return mem_alu_res;
            2'b01:   return wb_wdata;
            2'b11:   return ret_data_q;
            default: return rf;
        endcase
    endfunction

    assign stall_raw = id_valid && ex_q.valid && ex_memread_q && (ex_q.rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_q.rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_q.rd)));

    // Reset dominates everything; a flush discards the stalled instruction anyway.
    assign flush = branch_taken && !reset;
    assign stall = stall_raw && !flush && !reset;

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign ifid_flush  = flush;
    assign idex_flush  = flush || stall;
    assign exmem_flush = flush && BrInMem;

    always_comb begin
        ex_d.valid    = id_valid;
        ex_d.rd       = id_rd;
        ex_d.regwrite = id_regwrite;
        ex_memread_d  = id_memread;
        ex_rs1_d      = id_rs1;
        ex_rs2_d      = id_rs2;
        if (stall_raw || branch_taken) begin
            ex_d         = '0;
            ex_memread_d = 1'b0;
            ex_rs1_d     = '0;
            ex_rs2_d     = '0;
        end
        mem_d         = ex_q;
        mem_memread_d = ex_memread_q;
        if (branch_taken && BrInMem) begin
            mem_d         = '0;
            mem_memread_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q          <= '0;
            ex_memread_q  <= 1'b0;
            ex_rs1_q      <= '0;
            ex_rs2_q      <= '0;
            mem_q         <= '0;
            mem_memread_q <= 1'b0;
            wb_q          <= '0;
            ret_q         <= '0;
            ret_data_q    <= '0;
        end else begin
            ex_q          <= ex_d;
            ex_memread_q  <= ex_memread_d;
            ex_rs1_q      <= ex_rs1_d;
            ex_rs2_q      <= ex_rs2_d;
            mem_q         <= mem_d;
            mem_memread_q <= mem_memread_d;
            wb_q          <= mem_q;
            ret_q         <= wb_q;
            ret_data_q    <= wb_wdata;
        end
    end

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!reset) begin
            fwd_a = fwd_sel(ex_rs1_q);
            fwd_b = fwd_sel(ex_rs2_q);
        end
    end

    assign ex_op_a = op_sel(fwd_a, ex_rs1_data);
    assign ex_op_b = op_sel(fwd_b, ex_rs2_data);

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two instances (branches resolved in MEM and in EX) share the
// same stimulus. A behavioural model holds the in-flight instructions as an array and computes
// every output from the hazard/forwarding rules; a negedge process compares both instances.
module tb_pipeline_hazard_unit;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam int CW   = 32;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rd;
        logic          regwrite;
        logic          memread;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset, id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread;
    logic            branch_taken;
    logic [AW-1:0]   id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] ex_rs1_data, ex_rs2_data, mem_alu_res, wb_wdata;

    logic [1:0]      pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_flush;
    logic [1:0]      fwd_a [2];
    logic [1:0]      fwd_b [2];
    logic [XLEN-1:0] ex_op_a [2];
    logic [XLEN-1:0] ex_op_b [2];
    logic [CW-1:0]   stall_cnt [2];
    logic [CW-1:0]   flush_cnt [2];

    pipeline_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .BR_STAGE(3), .CNT_W(CW)) u_dut_mem (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .mem_alu_res(mem_alu_res),
        .wb_wdata(wb_wdata), .pc_stall(pc_stall[0]), .ifid_stall(ifid_stall[0]),
        .ifid_flush(ifid_flush[0]), .idex_flush(idex_flush[0]), .exmem_flush(exmem_flush[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0]), .ex_op_a(ex_op_a[0]), .ex_op_b(ex_op_b[0]),
        .stall_cnt(stall_cnt[0]), .flush_cnt(flush_cnt[0])
    );

    pipeline_hazard_unit #(.XLEN(XLEN), .REG_AW(AW), .BR_STAGE(2), .CNT_W(CW)) u_dut_ex (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .mem_alu_res(mem_alu_res),
        .wb_wdata(wb_wdata), .pc_stall(pc_stall[1]), .ifid_stall(ifid_stall[1]),
        .ifid_flush(ifid_flush[1]), .idex_flush(idex_flush[1]), .exmem_flush(exmem_flush[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1]), .ex_op_a(ex_op_a[1]), .ex_op_b(ex_op_b[1]),
        .stall_cnt(stall_cnt[1]), .flush_cnt(flush_cnt[1])
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input string s, input int i);
        return $sformatf("%s[%0d]", s, i);
    endfunction

    // ---------------- behavioural model ----------------
    // pipe[i][0..3] = instruction in EX, MEM, WB, retire buffer
    rec_t            pipe [2][4];
    logic [XLEN-1:0] m_ret_data [2];
    logic [CW-1:0]   m_scnt [2];
    logic [CW-1:0]   m_fcnt [2];

    function automatic int br_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic logic m_stall(input int i);
        rec_t e;
        e = pipe[i][0];
        return id_valid && e.valid && e.memread && (e.rd != 0) &&
               ((id_use_rs1 && (id_rs1 == e.rd)) || (id_use_rs2 && (id_rs2 == e.rd)));
    endfunction

    function automatic logic cand(input rec_t r, input logic [AW-1:0] idx);
        return r.valid && r.regwrite && (r.rd != 0) && (r.rd == idx);
    endfunction

    function automatic logic [1:0] m_fwd(input int i, input logic [AW-1:0] idx);
        if (cand(pipe[i][1], idx) && !pipe[i][1].memread) return 2'b10;
        if (cand(pipe[i][2], idx)) return 2'b01;
        if (cand(pipe[i][3], idx)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [XLEN-1:0] m_op(input int i, input logic [1:0] f,
                                             input logic [XLEN-1:0] rf);
        case (f)
            2'b10:   return mem_alu_res;
            2'b01:   return wb_wdata;
            2'b11:   return m_ret_data[i];
            default: return rf;
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int k = 0; k < 4; k++) pipe[i][k] = '0;
                m_ret_data[i] = '0;
                m_scnt[i] = '0;
                m_fcnt[i] = '0;
            end else begin
                logic st;
                rec_t idr;
                st = m_stall(i);
                if (st && !branch_taken && (m_scnt[i] != '1)) m_scnt[i] = m_scnt[i] + 1;
                if (branch_taken && (m_fcnt[i] != '1)) m_fcnt[i] = m_fcnt[i] + 1;
                idr = '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread,
                        rs1: id_rs1, rs2: id_rs2};
                m_ret_data[i] = wb_wdata;
                pipe[i][3] = pipe[i][2];
                pipe[i][2] = pipe[i][1];
                pipe[i][1] = (branch_taken && br_of(i) == 3) ? '0 : pipe[i][0];
                pipe[i][0] = (branch_taken || st) ? '0 : idr;
            end
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic st, br;
                logic [1:0] fa, fb;
                br = !reset && branch_taken;
                st = !reset && m_stall(i) && !br;
                chk(nm("pc_stall", i), 64'(pc_stall[i]), 64'(st));
                chk(nm("ifid_stall", i), 64'(ifid_stall[i]), 64'(st));
                chk(nm("ifid_flush", i), 64'(ifid_flush[i]), 64'(br));
                chk(nm("idex_flush", i), 64'(idex_flush[i]), 64'(br || st));
                chk(nm("exmem_flush", i), 64'(exmem_flush[i]), 64'(br && br_of(i) == 3));
                if (!reset && pipe[i][0].valid) begin
                    fa = m_fwd(i, pipe[i][0].rs1);
                    fb = m_fwd(i, pipe[i][0].rs2);
                    chk(nm("fwd_a", i), 64'(fwd_a[i]), 64'(fa));
                    chk(nm("fwd_b", i), 64'(fwd_b[i]), 64'(fb));
                    chk(nm("ex_op_a", i), ex_op_a[i], m_op(i, fa, ex_rs1_data));
                    chk(nm("ex_op_b", i), ex_op_b[i], m_op(i, fb, ex_rs2_data));
                end
                chk(nm("stall_cnt", i), 64'(stall_cnt[i]), PERF ? 64'(m_scnt[i]) : 64'd0);
                chk(nm("flush_cnt", i), 64'(flush_cnt[i]), PERF ? 64'(m_fcnt[i]) : 64'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rd, input logic rw, input logic mr,
                          input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2);
        id_valid = v; id_rd = rd; id_regwrite = rw; id_memread = mr;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        branch_taken = 1'b0;
        ex_rs1_data = 64'h11; ex_rs2_data = 64'h22; mem_alu_res = 64'h33; wb_wdata = 64'h44;
        nop();
        repeat (3) tick();
        reset = 1'b0;
        chk_en = 1'b1;
        settle();
        chk("reset_pc_stall", 64'(pc_stall[0]), 64'd0);
        chk("reset_idex_flush", 64'(idex_flush[0]), 64'd0);
        chk("reset_stall_cnt", 64'(stall_cnt[0]), 64'd0);

        // ld x5,0(x1); add x6,x5,x2
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1);
        settle();
        chk("ld_use_pc_stall", 64'(pc_stall[0]), 64'd1);
        chk("ld_use_ifid_stall", 64'(ifid_stall[0]), 64'd1);
        chk("ld_use_idex_flush", 64'(idex_flush[1]), 64'd1);
        tick();
        settle();
        chk("ld_use_one_cycle", 64'(pc_stall[0]), 64'd0);
        tick();
        nop();
        wb_wdata = 64'hDEAD_BEEF_0000_0055;
        settle();
        chk("ld_use_fwd_a", 64'(fwd_a[0]), 64'd1);
        chk("ld_use_op_a", ex_op_a[0], 64'hDEAD_BEEF_0000_0055);

        // add x5,x1,x2 (=7); sub x6,x5,x3
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd3, 1'b1);
        tick();
        nop();
        mem_alu_res = 64'd7;
        settle();
        chk("alu_fwd_a", 64'(fwd_a[1]), 64'd2);
        chk("alu_op_a", ex_op_a[1], 64'd7);

        // add x5 (=3); add x5 (=9); use x5 -> youngest wins
        set_id(1'b1, 5'd5, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd1, 1'b1, 5'd5, 1'b1);
        tick();
        nop();
        mem_alu_res = 64'd9;
        wb_wdata = 64'd3;
        settle();
        chk("youngest_fwd_b", 64'(fwd_b[0]), 64'd2);
        chk("youngest_op_b", ex_op_b[0], 64'd9);

        // addi x0,x0,5; add x6,x0,x1
        set_id(1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd0, 1'b1, 5'd1, 1'b1);
        tick();
        nop();
        ex_rs1_data = 64'h1234;
        mem_alu_res = 64'd5;
        settle();
        chk("x0_fwd_a", 64'(fwd_a[0]), 64'd0);
        chk("x0_op_a", ex_op_a[0], 64'h1234);

        // distance-3 dependence through the retire buffer
        set_id(1'b1, 5'd7, 1'b1, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1);
        tick();
        nop();
        tick();
        tick();
        wb_wdata = 64'hCAFE_F00D;
        set_id(1'b1, 5'd8, 1'b1, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0);
        tick();
        nop();
        wb_wdata = 64'h0BAD;
        settle();
        chk("ret_fwd_a", 64'(fwd_a[0]), 64'd3);
        chk("ret_op_a", ex_op_a[0], 64'hCAFE_F00D);

        // branch_taken together with a load-use stall
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1);
        branch_taken = 1'b1;
        settle();
        chk("br_ifid_flush", 64'(ifid_flush[0]), 64'd1);
        chk("br_idex_flush", 64'(idex_flush[0]), 64'd1);
        chk("br_exmem_flush", 64'(exmem_flush[0]), 64'd1);
        chk("br_pc_stall", 64'(pc_stall[0]), 64'd0);
        chk("br_ex_exmem_flush", 64'(exmem_flush[1]), 64'd0);
        tick();
        branch_taken = 1'b0;
        nop();
        settle();
        chk("br_stall_cnt", 64'(stall_cnt[0]), PERF ? 64'd1 : 64'd0);
        chk("br_flush_cnt", 64'(flush_cnt[0]), PERF ? 64'd1 : 64'd0);

        // reset during a stall
        set_id(1'b1, 5'd5, 1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0);
        tick();
        set_id(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd2, 1'b1);
        settle();
        chk("rst_pre_pc_stall", 64'(pc_stall[0]), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk("rst_pc_stall", 64'(pc_stall[0]), 64'd0);
        chk("rst_idex_flush", 64'(idex_flush[0]), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt[0]), 64'd0);
        chk("rst_flush_cnt", 64'(flush_cnt[1]), 64'd0);
        nop();

        // randomized traffic on a small register set to provoke frequent hazards
        for (int c = 0; c < 4000; c++) begin
            tick();
            reset        = ($urandom_range(0, 99) == 0);
            branch_taken = ($urandom_range(0, 99) < 8);
            set_id($urandom_range(0, 9) != 0, AW'($urandom_range(0, 3)),
                   $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                   AW'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                   AW'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
            ex_rs1_data = {$urandom, $urandom};
            ex_rs2_data = {$urandom, $urandom};
            mem_alu_res = {$urandom, $urandom};
            wb_wdata    = {$urandom, $urandom};
        end
        settle();
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
